// File: rtl/rtc_bus_writer_if.sv
// Transaction request/response and RTC multiplexed AD-bus signals for rtc_bus_writer.
// The master side issues requests and models the RTC pins; the slave side is the writer.
interface rtc_bus_writer_if;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;
  logic       ad_sel;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;

  modport master (
    output start, rw, addr, wdata, ad_in,
    input  busy, done, rdata, ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n
  );

  modport slave (
    input  start, rw, addr, wdata, ad_in,
    output busy, done, rdata, ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n
  );
endinterface

// File: rtl/rtc_bus_writer.sv
// Drives one address/data transaction onto the RTC's multiplexed AD bus with
// cycle-timed setup/pulse/hold phases; every bus output is a flop.
module rtc_bus_writer #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 3
) (
  input  logic           clk,
  input  logic           reset,
  rtc_bus_writer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_A_SETUP, S_A_PULSE, S_A_HOLD, S_GAP,
    S_D_SETUP, S_D_PULSE, S_D_HOLD, S_DONE
  } state_e;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_sel;
    logic       ad_oe;
    logic [7:0] ad_out;
  } bus_out_t;

  localparam bus_out_t IDLE_OUT = '{busy: 1'b0, done: 1'b0, cs_n: 1'b1, rd_n: 1'b1,
                                    wr_n: 1'b1, ad_sel: 1'b0, ad_oe: 1'b0, ad_out: 8'h00};

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rw_q, rw_d;
  logic [7:0] rdata_q, rdata_d;
  bus_out_t   out_q, out_d;

  // Counter reload value for a timed state: it counts down to 0 and the state exits on 0.
  function automatic logic [7:0] load_of(state_e s);
    case (s)
      S_A_SETUP, S_D_SETUP: load_of = 8'(T_SETUP - 1);
      S_A_PULSE, S_D_PULSE: load_of = 8'(T_PULSE - 1);
      S_A_HOLD,  S_D_HOLD:  load_of = 8'(T_HOLD - 1);
      S_GAP:                load_of = 8'(T_GAP - 1);
      default:              load_of = 8'h00;
    endcase
  endfunction

  function automatic state_e next_of(state_e s);
    case (s)
      S_A_SETUP: next_of = S_A_PULSE;
      S_A_PULSE: next_of = S_A_HOLD;
      S_A_HOLD:  next_of = S_GAP;
      S_GAP:     next_of = S_D_SETUP;
      S_D_SETUP: next_of = S_D_PULSE;
      S_D_PULSE: next_of = S_D_HOLD;
      S_D_HOLD:  next_of = S_DONE;
      default:   next_of = S_IDLE;
    endcase
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_A_SETUP;
          cnt_d   = load_of(S_A_SETUP);
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          rw_d    = bus.rw;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 8'h00;
      end
      default: begin
        if (cnt_q == 8'h00) begin
          state_d = next_of(state_q);
          cnt_d   = load_of(next_of(state_q));
          // The read strobe is still low at this edge, so the RTC's data is valid on ad_in.
          if (state_q == S_D_PULSE && rw_q) rdata_d = bus.ad_in;
        end else begin
          cnt_d = cnt_q - 8'h01;
        end
      end
    endcase

    // Outputs are decoded from the state being entered, then registered.
    out_d      = IDLE_OUT;
    out_d.busy = (state_d != S_IDLE);
    case (state_d)
      S_A_SETUP, S_A_PULSE, S_A_HOLD: begin
        out_d.cs_n   = 1'b0;
        out_d.ad_oe  = 1'b1;
        out_d.ad_out = addr_d;
        out_d.wr_n   = (state_d != S_A_PULSE);
      end
      S_D_SETUP, S_D_PULSE, S_D_HOLD: begin
        out_d.cs_n   = 1'b0;
        out_d.ad_sel = 1'b1;
        out_d.ad_oe  = ~rw_d;
        out_d.ad_out = rw_d ? 8'h00 : wdata_d;
        out_d.wr_n   = ~(state_d == S_D_PULSE && !rw_d);
        out_d.rd_n   = ~(state_d == S_D_PULSE && rw_d);
      end
      S_DONE:  out_d.done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'h00;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rw_q    <= 1'b0;
      rdata_q <= 8'h00;
      out_q   <= IDLE_OUT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy   = out_q.busy;
  assign bus.done   = out_q.done;
  assign bus.cs_n   = out_q.cs_n;
  assign bus.rd_n   = out_q.rd_n;
  assign bus.wr_n   = out_q.wr_n;
  assign bus.ad_sel = out_q.ad_sel;
  assign bus.ad_oe  = out_q.ad_oe;
  assign bus.ad_out = out_q.ad_out;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_rtc_bus_writer.sv
// Self-checking bench for rtc_bus_writer: per-cycle bus model, vector table,
// rdata scoreboard and hand-written reset/back-to-back/fast-timing sequences.
module tb_rtc_bus_writer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_sel;
    logic       ad_oe;
    logic [7:0] ad_out;
  } bus_t;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd_val;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] rd_val = 8'h00;
  logic [7:0] exp_rdata = 8'h00;
  logic [7:0] sb_q[$];
  int n_vec = 0;
  int n_bad = 0;

  rtc_bus_writer_if ifc0();
  rtc_bus_writer_if ifc1();

  rtc_bus_writer dut0 (.clk(clk), .reset(reset), .bus(ifc0));
  rtc_bus_writer #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1))
    dut1 (.clk(clk), .reset(reset), .bus(ifc1));

  always #5 clk = ~clk;

  // RTC model: drives the read value only while the read strobe is low.
  assign ifc0.ad_in = (!ifc0.rd_n) ? rd_val : 8'hEE;
  assign ifc1.ad_in = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Expected bus value on cycle i after the accepting edge (i=1 is the first busy cycle).
  function automatic bus_t model(int i, int ts, int tp, int th, int tg,
                                 logic rw, logic [7:0] a, logic [7:0] w);
    bus_t b = '{busy: 1'b0, done: 1'b0, cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                ad_sel: 1'b0, ad_oe: 1'b0, ad_out: 8'h00};
    int ph = ts + tp + th;
    int j;
    if (i >= 1 && i <= ph) begin
      b.busy = 1'b1; b.cs_n = 1'b0; b.ad_oe = 1'b1; b.ad_out = a;
      if (i > ts && i <= ts + tp) b.wr_n = 1'b0;
    end else if (i > ph && i <= ph + tg) begin
      b.busy = 1'b1;
    end else if (i > ph + tg && i <= 2 * ph + tg) begin
      j = i - ph - tg;
      b.busy = 1'b1; b.cs_n = 1'b0; b.ad_sel = 1'b1;
      b.ad_oe = !rw; b.ad_out = rw ? 8'h00 : w;
      if (j > ts && j <= ts + tp) begin
        if (rw) b.rd_n = 1'b0; else b.wr_n = 1'b0;
      end
    end else if (i == 2 * ph + tg + 1) begin
      b.busy = 1'b1; b.done = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [31:0] pack0();
    bus_t b;
    b = '{busy: ifc0.busy, done: ifc0.done, cs_n: ifc0.cs_n, rd_n: ifc0.rd_n,
          wr_n: ifc0.wr_n, ad_sel: ifc0.ad_sel, ad_oe: ifc0.ad_oe, ad_out: ifc0.ad_out};
    return 32'(b);
  endfunction

  // Compares dut0 against the model on cycles from..to; pops the scoreboard on done.
  task automatic check_cycles(input int from, input int to, input logic rw,
                              input logic [7:0] a, input logic [7:0] w);
    logic [7:0] want;
    for (int i = from; i <= to; i++) begin
      @(negedge clk);
      check($sformatf("bus cyc%0d a=%h", i, a), pack0(), 32'(model(i, 2, 4, 2, 3, rw, a, w)));
      if (ifc0.ad_oe && !ifc0.rd_n) check("oe_rd_overlap", 32'd1, 32'd0);
      if (ifc0.done) begin
        if (sb_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else begin
          want = sb_q.pop_front();
          check($sformatf("rdata a=%h", a), 32'(ifc0.rdata), 32'(want));
        end
      end
    end
  endtask

  task automatic push_exp(input logic rw, input logic [7:0] v);
    if (rw) exp_rdata = v;
    sb_q.push_back(exp_rdata);
  endtask

  task automatic run_txn(input logic rw, input logic [7:0] a, input logic [7:0] w,
                         input logic [7:0] v);
    @(negedge clk);
    ifc0.start = 1'b1; ifc0.rw = rw; ifc0.addr = a; ifc0.wdata = w;
    rd_val = v;
    push_exp(rw, v);
    @(posedge clk);
    #1 ifc0.start = 1'b0;
    check_cycles(1, 21, rw, a, w);
  endtask

  vec_t vecs[6];
  int busy_cnt;
  int done_cnt;
  bus_t fb;

  initial begin
    vecs[0] = '{rw: 1'b0, addr: 8'h02, wdata: 8'h10, rd_val: 8'h00};
    vecs[1] = '{rw: 1'b1, addr: 8'h21, wdata: 8'h99, rd_val: 8'h45};
    vecs[2] = '{rw: 1'b0, addr: 8'hFF, wdata: 8'h00, rd_val: 8'h33};
    vecs[3] = '{rw: 1'b1, addr: 8'h00, wdata: 8'h00, rd_val: 8'hFF};
    vecs[4] = '{rw: 1'b0, addr: 8'hA5, wdata: 8'h5A, rd_val: 8'h00};
    vecs[5] = '{rw: 1'b1, addr: 8'h7F, wdata: 8'hC3, rd_val: 8'h80};

    ifc0.start = 1'($urandom); ifc0.rw = 1'($urandom);
    ifc0.addr = 8'($urandom); ifc0.wdata = 8'($urandom);
    ifc1.start = 1'b0; ifc1.rw = 1'b0; ifc1.addr = 8'h00; ifc1.wdata = 8'h00;

    // Reset takes effect before the first clock edge.
    #1 reset = 1'b1;
    #1;
    check("reset_bus", pack0(), 32'(model(0, 2, 4, 2, 3, 1'b0, 8'h00, 8'h00)));
    check("reset_rdata", 32'(ifc0.rdata), 32'h00);
    ifc0.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[k]) run_txn(vecs[k].rw, vecs[k].addr, vecs[k].wdata, vecs[k].rd_val);

    // start held high with addr changed mid-transaction: original addr, one IDLE, then new addr.
    @(negedge clk);
    ifc0.start = 1'b1; ifc0.rw = 1'b0; ifc0.addr = 8'h30; ifc0.wdata = 8'h44;
    push_exp(1'b0, 8'h00);
    push_exp(1'b0, 8'h00);
    @(posedge clk);
    check_cycles(1, 4, 1'b0, 8'h30, 8'h44);
    ifc0.addr = 8'h31; ifc0.wdata = 8'h55;
    check_cycles(5, 21, 1'b0, 8'h30, 8'h44);
    check_cycles(1, 20, 1'b0, 8'h31, 8'h55);
    ifc0.start = 1'b0;
    check_cycles(21, 21, 1'b0, 8'h31, 8'h55);

    // Reset during the data-phase write strobe aborts with no done pulse.
    @(negedge clk);
    ifc0.start = 1'b1; ifc0.rw = 1'b0; ifc0.addr = 8'h55; ifc0.wdata = 8'h66;
    @(posedge clk);
    #1 ifc0.start = 1'b0;
    repeat (14) @(negedge clk);
    check("abort_in_dpulse", 32'(ifc0.wr_n), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_bus", pack0(), 32'(model(0, 2, 4, 2, 3, 1'b0, 8'h00, 8'h00)));
    done_cnt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_rdata = 8'h00;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ifc0.done || ifc0.busy) done_cnt++;
    end
    check("abort_no_resume", 32'(done_cnt), 32'd0);
    check("abort_rdata", 32'(ifc0.rdata), 32'h00);
    run_txn(1'b0, 8'h10, 8'hD2, 8'h00);

    // Fastest timing on dut1: 8 busy cycles, one-cycle strobes.
    @(negedge clk);
    ifc1.start = 1'b1; ifc1.rw = 1'b0; ifc1.addr = 8'h3C; ifc1.wdata = 8'hC3;
    @(posedge clk);
    #1 ifc1.start = 1'b0;
    busy_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      fb = '{busy: ifc1.busy, done: ifc1.done, cs_n: ifc1.cs_n, rd_n: ifc1.rd_n,
             wr_n: ifc1.wr_n, ad_sel: ifc1.ad_sel, ad_oe: ifc1.ad_oe, ad_out: ifc1.ad_out};
      check($sformatf("fast cyc%0d", i), 32'(fb),
            32'(model(i, 1, 1, 1, 1, 1'b0, 8'h3C, 8'hC3)));
      if (ifc1.busy) busy_cnt++;
    end
    check("fast_busy_len", 32'(busy_cnt), 32'd8);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
